// File: rtl/block_transfer_sequencer.sv
// Data-phase sequencer for SD DMA transfers: counts blocks, gates the data path,
// requests CMD12 when the transfer type needs it and pulses completion.
module block_transfer_sequencer #(
    parameter int BC_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          Transfer_Type,
    input  logic [BC_WIDTH-1:0] Block_Count,
    input  logic                Start,
    input  logic                Block_Done,
    input  logic                Stop_Request,
    input  logic                Stop_Cmd_Ack,
    output logic                Busy,
    output logic                Block_Enable,
    output logic                Stop_Cmd_Req,
    output logic                Transfer_Complete,
    output logic [BC_WIDTH-1:0] Blocks_Transferred
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        STOP = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] TYPE_SINGLE    = 2'b00;
    localparam logic [1:0] TYPE_INFINITE  = 2'b01;
    localparam logic [1:0] TYPE_MULTI_STOP = 2'b11;

    state_t              state, next_state;
    logic [1:0]          type_q;
    logic [BC_WIDTH-1:0] count_q;
    logic [BC_WIDTH-1:0] count_inc;
    logic [BC_WIDTH-1:0] target;
    logic                last_block;

    assign count_inc  = Blocks_Transferred + BC_WIDTH'(1);
    assign target     = (type_q == TYPE_SINGLE) ? BC_WIDTH'(1) : count_q;
    // The block is counted before the stop request is considered, so a
    // simultaneous last Block_Done wins over Stop_Request.
    assign last_block = Block_Done && (type_q != TYPE_INFINITE) && (count_inc == target);

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    if (Transfer_Type[1] && (Block_Count == '0))
                        next_state = DONE;
                    else
                        next_state = XFER;
                end
            end
            XFER: begin
                if (last_block)
                    next_state = (type_q == TYPE_MULTI_STOP) ? STOP : DONE;
                else if (Stop_Request)
                    next_state = (type_q == TYPE_SINGLE) ? DONE : STOP;
            end
            STOP: begin
                if (Stop_Cmd_Ack)
                    next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: non-blocking assignments for all sequential state to avoid ordering races.
            state              <= IDLE;
            type_q             <= '0;
            count_q            <= '0;
            Blocks_Transferred <= '0;
            Busy               <= 1'b0;
            Block_Enable       <= 1'b0;
            Stop_Cmd_Req       <= 1'b0;
            Transfer_Complete  <= 1'b0;
        end else begin
            state             <= next_state;
            Busy              <= (next_state != IDLE);
            Block_Enable      <= (next_state == XFER);
            Stop_Cmd_Req      <= (next_state == STOP);
            Transfer_Complete <= (next_state == DONE);

            if (state == IDLE && Start) begin
                type_q             <= Transfer_Type;
                count_q            <= Block_Count;
                Blocks_Transferred <= '0;
            end else if ((state == XFER || state == STOP) && Block_Done) begin
                Blocks_Transferred <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed self-checking bench for block_transfer_sequencer.
module tb_block_transfer_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  Transfer_Type = 2'b00;
    logic [15:0] Block_Count = '0;
    logic        Start = 1'b0;
    logic        Block_Done = 1'b0;
    logic        Stop_Request = 1'b0;
    logic        Stop_Cmd_Ack = 1'b0;
    logic        Busy, Block_Enable, Stop_Cmd_Req, Transfer_Complete;
    logic [15:0] Blocks_Transferred;

    int n_tests = 0;
    int n_fail  = 0;
    int scr_cnt = 0;
    int tc_cnt  = 0;

    block_transfer_sequencer #(.BC_WIDTH(16)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Transfer_Type      (Transfer_Type),
        .Block_Count        (Block_Count),
        .Start              (Start),
        .Block_Done         (Block_Done),
        .Stop_Request       (Stop_Request),
        .Stop_Cmd_Ack       (Stop_Cmd_Ack),
        .Busy               (Busy),
        .Block_Enable       (Block_Enable),
        .Stop_Cmd_Req       (Stop_Cmd_Req),
        .Transfer_Complete  (Transfer_Complete),
        .Blocks_Transferred (Blocks_Transferred)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (Stop_Cmd_Req) scr_cnt++;
        if (Transfer_Complete) tc_cnt++;
    endtask

    task automatic start_xfer(input logic [1:0] t, input logic [15:0] n);
        Transfer_Type = t;
        Block_Count   = n;
        Start         = 1'b1;
        tick();
        Start         = 1'b0;
    endtask

    task automatic pulse_bd();
        Block_Done = 1'b1;
        tick();
        Block_Done = 1'b0;
    endtask

    task automatic pulse_ack();
        Stop_Cmd_Ack = 1'b1;
        tick();
        Stop_Cmd_Ack = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", Busy, 0);
        check("rst_be", Block_Enable, 0);
        check("rst_scr", Stop_Cmd_Req, 0);
        check("rst_tc", Transfer_Complete, 0);
        check("rst_bt", Blocks_Transferred, 0);
        RESET = 1'b1;
        tick();

        // Single block
        scr_cnt = 0;
        start_xfer(2'b00, 16'd9);
        check("single_be", Block_Enable, 1);
        check("single_busy", Busy, 1);
        pulse_bd();
        check("single_tc", Transfer_Complete, 1);
        check("single_bt", Blocks_Transferred, 1);
        tick();
        check("single_tc_1cyc", Transfer_Complete, 0);
        check("single_idle", Busy, 0);
        check("single_no_scr", scr_cnt, 0);

        // Multiple without stop, pulses 3 cycles apart
        scr_cnt = 0;
        start_xfer(2'b10, 16'd4);
        for (int i = 1; i <= 4; i++) begin
            pulse_bd();
            check($sformatf("multi_bt%0d", i), Blocks_Transferred, i);
            check($sformatf("multi_tc%0d", i), Transfer_Complete, (i == 4) ? 1 : 0);
            if (i < 4) begin
                tick();
                tick();
            end
        end
        tick();
        check("multi_idle", Busy, 0);
        check("multi_no_scr", scr_cnt, 0);

        // Multiple with stop
        scr_cnt = 0;
        start_xfer(2'b11, 16'd3);
        for (int i = 0; i < 3; i++) pulse_bd();
        check("mstop_scr", Stop_Cmd_Req, 1);
        check("mstop_be", Block_Enable, 0);
        check("mstop_tc_early", Transfer_Complete, 0);
        for (int i = 0; i < 4; i++) tick();
        check("mstop_scr_held", scr_cnt, 5);
        pulse_ack();
        check("mstop_tc", Transfer_Complete, 1);
        check("mstop_scr_off", Stop_Cmd_Req, 0);
        check("mstop_bt", Blocks_Transferred, 3);
        tick();

        // Infinite, 70000 blocks then abort
        start_xfer(2'b01, 16'd0);
        Block_Done = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        Block_Done = 1'b0;
        check("inf_bt_wrap", Blocks_Transferred, 4464);
        check("inf_be", Block_Enable, 1);
        Stop_Request = 1'b1;
        tick();
        Stop_Request = 1'b0;
        check("inf_stop", Stop_Cmd_Req, 1);
        pulse_bd();
        check("inf_inflight_bd", Blocks_Transferred, 4465);
        pulse_ack();
        check("inf_tc", Transfer_Complete, 1);
        tick();

        // Infinite, Block_Done and Stop_Request together
        start_xfer(2'b01, 16'd0);
        for (int i = 0; i < 5; i++) pulse_bd();
        Block_Done = 1'b1;
        Stop_Request = 1'b1;
        tick();
        Block_Done = 1'b0;
        Stop_Request = 1'b0;
        check("inf_same_bt", Blocks_Transferred, 6);
        check("inf_same_stop", Stop_Cmd_Req, 1);
        pulse_ack();
        tick();

        // Multiple, last block coincident with Stop_Request: DONE, not STOP
        scr_cnt = 0;
        start_xfer(2'b10, 16'd2);
        pulse_bd();
        Block_Done = 1'b1;
        Stop_Request = 1'b1;
        tick();
        Block_Done = 1'b0;
        Stop_Request = 1'b0;
        check("mlast_tc", Transfer_Complete, 1);
        check("mlast_bt", Blocks_Transferred, 2);
        check("mlast_no_scr", scr_cnt, 0);
        tick();

        // Single, abort before block: DONE with no CMD12
        scr_cnt = 0;
        start_xfer(2'b00, 16'd0);
        Stop_Request = 1'b1;
        tick();
        Stop_Request = 1'b0;
        check("sabort_tc", Transfer_Complete, 1);
        check("sabort_bt", Blocks_Transferred, 0);
        check("sabort_no_scr", scr_cnt, 0);
        tick();

        // Zero count
        start_xfer(2'b10, 16'd0);
        check("zero_tc", Transfer_Complete, 1);
        check("zero_be", Block_Enable, 0);
        check("zero_bt", Blocks_Transferred, 0);
        tick();
        check("zero_idle", Busy, 0);

        // Block_Done in IDLE is ignored
        pulse_bd();
        check("idle_bd_ignored", Blocks_Transferred, 0);

        // Ignored Start and reset mid-transfer
        start_xfer(2'b11, 16'd8);
        pulse_bd();
        pulse_bd();
        start_xfer(2'b00, 16'd1);
        check("restart_bt", Blocks_Transferred, 2);
        check("restart_be", Block_Enable, 1);
        for (int i = 0; i < 3; i++) pulse_bd();
        check("prereset_bt", Blocks_Transferred, 5);
        scr_cnt = 0;
        tc_cnt  = 0;
        RESET = 1'b0;
        #1;
        check("mrst_busy", Busy, 0);
        check("mrst_be", Block_Enable, 0);
        check("mrst_bt", Blocks_Transferred, 0);
        check("mrst_scr", Stop_Cmd_Req, 0);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        tick();
        check("mrst_no_tc", tc_cnt, 0);
        check("mrst_no_scr", scr_cnt, 0);
        check("mrst_idle", Busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
